// File: rtl/cpu_fetch_pkg.sv
// Shared types for the instruction-fetch front end: fetch FSM states and the
// buffered queue entry.
package cpu_fetch_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/cpu_sync_fifo.sv
// Circular-buffer FIFO with extra-bit pointers, a synchronous clear and a
// registered head word so consumers never see a combinational storage read.
module cpu_sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             valid_reg;
    logic             full, push_ok, pop_ok;
    logic [AW:0]      count_next;
    logic [AW-1:0]    rd_next_idx;

    assign count       = wr_ptr_reg - rd_ptr_reg;
    assign full        = (count == CW'(DEPTH));
    assign pop_ok      = pop && valid_reg;
    assign push_ok     = push && (!full || pop_ok);
    assign rd_next_idx = rd_ptr_reg[AW-1:0] + AW'(1);
    assign count_next  = count + CW'(push_ok) - CW'(pop_ok);

    // The head register is refreshed from storage, or from the incoming word
    // when the queue is (or becomes) otherwise empty.
    always_comb begin
        head_next = head_reg;
        if (pop_ok && count > CW'(1))
            head_next = mem[rd_next_idx];
        else if (push_ok && (count == '0 || pop_ok))
            head_next = push_data;
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear)
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
            valid_reg  <= 1'b0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + CW'(1);
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + CW'(1);
            head_reg  <= head_next;
            valid_reg <= (count_next != '0);
        end
    end

    assign head_data  = head_reg;
    assign head_valid = valid_reg;
endmodule

// File: rtl/cpu_fetch_queue.sv
// Decoupled instruction prefetch queue: issues sequential fetches ahead of
// decode, buffers them with their PCs, and flushes/restarts on redirect.
module cpu_fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              PC_STEP  = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [XLEN-1:0]           instr_address_out,
    output logic                      instr_read_out,
    input  logic [XLEN-1:0]           instr_read_value_in,
    input  logic                      instr_ready_in,
    input  logic                      redirect_in,
    input  logic [XLEN-1:0]           redirect_pc_in,
    output logic                      valid_out,
    input  logic                      stall_in,
    output logic [XLEN-1:0]           pc_out,
    output logic [ILEN-1:0]           instr_out,
    output logic [$clog2(DEPTH):0]    count_out
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t          state_reg;
    logic [XLEN-1:0]       fpc_reg, drop_addr_reg;
    logic                  started_reg;
    logic                  req_active, complete, push, pop, stay_req;
    logic [CW-1:0]         fifo_count;
    logic [XLEN+ILEN-1:0]  head_data;

    // started_reg holds off the first request until one clock after reset release.
    assign req_active = (state_reg != IDLE) ||
                        (started_reg && (fifo_count < CW'(DEPTH)));
    assign complete   = req_active && instr_ready_in;
    assign push       = complete && !redirect_in && (state_reg != DROP);
    assign pop        = valid_out && !stall_in && !redirect_in;
    assign stay_req   = (int'(fifo_count) + 1 - int'(pop)) < DEPTH;

    assign instr_read_out    = req_active;
    assign instr_address_out = (state_reg == DROP) ? drop_addr_reg : fpc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            fpc_reg       <= RESET_PC;
            drop_addr_reg <= RESET_PC;
            started_reg   <= 1'b0;
        end else begin
            started_reg <= 1'b1;
            if (redirect_in) begin
                fpc_reg <= redirect_pc_in;
                if (req_active && !instr_ready_in) begin
                    state_reg <= DROP;
                    // Keep the original in-flight address across repeated redirects.
                    if (state_reg != DROP)
                        drop_addr_reg <= fpc_reg;
                end else begin
                    state_reg <= IDLE;
                end
            end else if (state_reg == DROP) begin
                if (instr_ready_in)
                    state_reg <= IDLE;
            end else if (complete) begin
                fpc_reg   <= fpc_reg + XLEN'(PC_STEP);
                state_reg <= stay_req ? REQ : IDLE;
            end else if (req_active) begin
                state_reg <= REQ;
            end
        end
    end

    cpu_sync_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect_in),
        .push       (push),
        .push_data  ({fpc_reg, instr_read_value_in[ILEN-1:0]}),
        .pop        (pop),
        .head_data  (head_data),
        .head_valid (valid_out),
        .count      (fifo_count)
    );

    generate
        if (XLEN > ILEN) begin : g_upper
            logic unused_read_bits;
            assign unused_read_bits = ^instr_read_value_in[XLEN-1:ILEN];
        end
    endgenerate

    assign pc_out    = head_data[XLEN+ILEN-1:ILEN];
    assign instr_out = head_data[ILEN-1:0];
    assign count_out = fifo_count;
endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Self-checking bench for cpu_fetch_queue: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_cpu_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [63:0] RESET_PC = 64'd0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   instr_address_out;
    logic          instr_read_out;
    logic [63:0]   instr_read_value_in = '0;
    logic          instr_ready_in = 1'b0;
    logic          redirect_in = 1'b0;
    logic [63:0]   redirect_pc_in = '0;
    logic          valid_out;
    logic          stall_in = 1'b1;
    logic [63:0]   pc_out;
    logic [31:0]   instr_out;
    logic [CW-1:0] count_out;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cpu_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk                 (clk),
        .reset               (reset),
        .instr_address_out   (instr_address_out),
        .instr_read_out      (instr_read_out),
        .instr_read_value_in (instr_read_value_in),
        .instr_ready_in      (instr_ready_in),
        .redirect_in         (redirect_in),
        .redirect_pc_in      (redirect_pc_in),
        .valid_out           (valid_out),
        .stall_in            (stall_in),
        .pc_out              (pc_out),
        .instr_out           (instr_out),
        .count_out           (count_out)
    );

    // Reference model: buffered entries, fetch PC and outstanding request.
    logic [63:0] q_pc[$];
    logic [31:0] q_ins[$];
    logic [63:0] m_fpc, m_drop_addr;
    bit          m_pend, m_drop, m_started;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return ((a[31:0] * 32'h9E37_79B1) ^ a[63:32]) + 32'h0000_0013;
    endfunction

    function automatic bit m_read();
        return m_started && (m_pend || q_pc.size() < DEPTH);
    endfunction

    function automatic logic [63:0] m_addr();
        return m_drop ? m_drop_addr : m_fpc;
    endfunction

    task automatic model_reset();
        q_pc.delete();
        q_ins.delete();
        m_fpc = RESET_PC; m_drop_addr = RESET_PC;
        m_pend = 0; m_drop = 0; m_started = 0;
    endtask

    // Drive one cycle of inputs (called just after a negedge), advance the
    // model by the same clock edge, and return at the next negedge.
    task automatic step(input bit rdy, input bit stl, input bit rdr, input logic [63:0] rpc);
        bit          rd;
        logic [63:0] a;
        bit          pop;
        instr_ready_in      = rdy;
        stall_in            = stl;
        redirect_in         = rdr;
        redirect_pc_in      = rpc;
        instr_read_value_in = {$urandom(), mem_word(instr_address_out)};
        rd  = m_read();
        a   = m_addr();
        pop = (q_pc.size() != 0) && !stl;
        if (rdr) begin
            q_pc.delete();
            q_ins.delete();
            if (rd && !rdy) begin
                if (!m_drop) m_drop_addr = a;
                m_drop = 1; m_pend = 1;
            end else begin
                m_drop = 0; m_pend = 0;
            end
            m_fpc = rpc;
        end else if (m_drop) begin
            if (rdy) begin m_drop = 0; m_pend = 0; end
        end else begin
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (rd && rdy) begin
                q_pc.push_back(m_fpc);
                q_ins.push_back(mem_word(m_fpc));
                m_fpc = m_fpc + 64'd4;
            end
            m_pend = rd && !rdy;
        end
        m_started = 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        total++; if (instr_read_out !== 1'b0) $display("FAIL reset_read got=%b exp=0", instr_read_out); else passed++;
        total++; if (instr_address_out !== RESET_PC) $display("FAIL reset_addr got=%h exp=%h", instr_address_out, RESET_PC); else passed++;
        total++; if (valid_out !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_out); else passed++;
        total++; if (count_out !== '0) $display("FAIL reset_count got=%0d exp=0", count_out); else passed++;
        total++; if (pc_out !== '0) $display("FAIL reset_pc got=%h exp=0", pc_out); else passed++;
        total++; if (instr_out !== '0) $display("FAIL reset_instr got=%h exp=0", instr_out); else passed++;
        reset = 1'b0;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 12; k++) begin
            if (k >= 2) begin
                total++;
                if (instr_read_out !== 1'b1 || instr_address_out !== 64'(4 * (k - 2)))
                    $display("FAIL stream_addr k=%0d got=%b/%h exp=1/%h", k, instr_read_out, instr_address_out, 64'(4 * (k - 2)));
                else passed++;
            end
            step(1, 0, 0, '0);
            if (k == 1) begin
                total++; if (valid_out !== 1'b0) $display("FAIL stream_early_valid got=%b exp=0", valid_out); else passed++;
            end else begin
                total++;
                if (valid_out !== 1'b1 || pc_out !== 64'(4 * (k - 2)) || instr_out !== mem_word(64'(4 * (k - 2))))
                    $display("FAIL stream_head k=%0d got=%b/%h/%h exp=1/%h/%h", k, valid_out, pc_out, instr_out,
                             64'(4 * (k - 2)), mem_word(64'(4 * (k - 2))));
                else passed++;
            end
        end
        $display("test_stream done");
    endtask

    task automatic test_stall();
        logic [63:0] prev_pc;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, '0);
            total++;
            if (count_out !== CW'(q_pc.size()) || instr_read_out !== m_read())
                $display("FAIL stall_fill i=%0d got=%0d/%b exp=%0d/%b", i, count_out, instr_read_out, q_pc.size(), m_read());
            else passed++;
        end
        total++; if (count_out !== CW'(DEPTH)) $display("FAIL stall_saturate got=%0d exp=%0d", count_out, DEPTH); else passed++;
        total++; if (instr_read_out !== 1'b0) $display("FAIL stall_read got=%b exp=0", instr_read_out); else passed++;
        prev_pc = pc_out - 64'd4;
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (valid_out !== 1'b1 || pc_out !== q_pc[0] || pc_out !== prev_pc + 64'd4 || instr_out !== q_ins[0])
                $display("FAIL stall_drain i=%0d got=%b/%h exp=1/%h", i, valid_out, pc_out, q_pc[0]);
            else passed++;
            prev_pc = pc_out;
            step(0, 0, 0, '0);
        end
        total++; if (valid_out !== 1'b0) $display("FAIL stall_empty got=%b exp=0", valid_out); else passed++;
        $display("test_stall done");
    endtask

    task automatic test_slow_mem();
        bit          prev_hold;
        logic [63:0] prev_addr;
        bit          rdy;
        prev_hold = 0;
        prev_addr = '0;
        for (int i = 0; i < 30; i++) begin
            if (prev_hold) begin
                total++;
                if (instr_read_out !== 1'b1 || instr_address_out !== prev_addr)
                    $display("FAIL slow_hold i=%0d got=%b/%h exp=1/%h", i, instr_read_out, instr_address_out, prev_addr);
                else passed++;
            end
            total++;
            if (count_out !== CW'(q_pc.size()) || valid_out !== (q_pc.size() != 0) ||
                (q_pc.size() != 0 && pc_out !== q_pc[0]))
                $display("FAIL slow_queue i=%0d got=%0d/%h exp=%0d", i, count_out, pc_out, q_pc.size());
            else passed++;
            rdy       = (i % 3 == 2);
            prev_hold = instr_read_out && !rdy;
            prev_addr = instr_address_out;
            step(rdy, ($urandom_range(0, 3) == 0), 0, '0);
        end
        $display("test_slow_mem done");
    endtask

    task automatic test_redirect_pending();
        logic [63:0] old_addr;
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        old_addr = m_addr();
        total++; if (instr_read_out !== 1'b1) $display("FAIL redir_pre_read got=%b exp=1", instr_read_out); else passed++;
        step(0, 1, 1, 64'h1000);
        total++; if (valid_out !== 1'b0) $display("FAIL redir_flush got=%b exp=0", valid_out); else passed++;
        total++;
        if (instr_read_out !== 1'b1 || instr_address_out !== old_addr)
            $display("FAIL redir_hold1 got=%b/%h exp=1/%h", instr_read_out, instr_address_out, old_addr);
        else passed++;
        step(0, 1, 0, '0);
        total++;
        if (instr_address_out !== old_addr) $display("FAIL redir_hold2 got=%h exp=%h", instr_address_out, old_addr);
        else passed++;
        step(1, 1, 0, '0);
        total++;
        if (valid_out !== 1'b0 || instr_read_out !== 1'b1 || instr_address_out !== 64'h1000)
            $display("FAIL redir_restart got=%b/%b/%h exp=0/1/1000", valid_out, instr_read_out, instr_address_out);
        else passed++;
        step(1, 1, 0, '0);
        total++;
        if (valid_out !== 1'b1 || pc_out !== 64'h1000 || count_out !== CW'(1))
            $display("FAIL redir_first got=%b/%h/%0d exp=1/1000/1", valid_out, pc_out, count_out);
        else passed++;
        $display("test_redirect_pending done");
    endtask

    task automatic test_redirect_same();
        step(1, 1, 0, '0);
        step(1, 1, 0, '0);
        total++;
        if (instr_read_out !== 1'b1 || valid_out !== 1'b1)
            $display("FAIL same_pre got=%b/%b exp=1/1", instr_read_out, valid_out);
        else passed++;
        step(1, 0, 1, 64'h2000);
        total++;
        if (valid_out !== 1'b0 || count_out !== '0)
            $display("FAIL same_flush got=%b/%0d exp=0/0", valid_out, count_out);
        else passed++;
        total++;
        if (instr_read_out !== 1'b1 || instr_address_out !== 64'h2000)
            $display("FAIL same_addr got=%b/%h exp=1/2000", instr_read_out, instr_address_out);
        else passed++;
        step(1, 1, 0, '0);
        total++;
        if (valid_out !== 1'b1 || pc_out !== 64'h2000 || count_out !== CW'(1))
            $display("FAIL same_first got=%b/%h/%0d exp=1/2000/1", valid_out, pc_out, count_out);
        else passed++;
        $display("test_redirect_same done");
    endtask

    task automatic test_wrap();
        logic [63:0] exp_a;
        step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8);
        for (int i = 0; i < 4; i++) begin
            exp_a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * i);
            total++;
            if (instr_read_out !== 1'b1 || instr_address_out !== exp_a)
                $display("FAIL wrap_addr i=%0d got=%b/%h exp=1/%h", i, instr_read_out, instr_address_out, exp_a);
            else passed++;
            step(1, 0, 0, '0);
            total++;
            if (valid_out !== 1'b1 || pc_out !== exp_a)
                $display("FAIL wrap_head i=%0d got=%b/%h exp=1/%h", i, valid_out, pc_out, exp_a);
            else passed++;
        end
        $display("test_wrap done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            total++;
            if (instr_read_out !== m_read())
                $display("FAIL rand_read i=%0d got=%b exp=%b", i, instr_read_out, m_read());
            else passed++;
            if (m_read()) begin
                total++;
                if (instr_address_out !== m_addr())
                    $display("FAIL rand_addr i=%0d got=%h exp=%h", i, instr_address_out, m_addr());
                else passed++;
            end
            total++;
            if (valid_out !== (q_pc.size() != 0) || count_out !== CW'(q_pc.size()))
                $display("FAIL rand_count i=%0d got=%b/%0d exp=%0d", i, valid_out, count_out, q_pc.size());
            else passed++;
            if (q_pc.size() != 0) begin
                total++;
                if (pc_out !== q_pc[0] || instr_out !== q_ins[0])
                    $display("FAIL rand_head i=%0d got=%h/%h exp=%h/%h", i, pc_out, instr_out, q_pc[0], q_ins[0]);
                else passed++;
            end
            step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3), ($urandom_range(0, 15) == 0),
                 {$urandom(), $urandom()} & ~64'h3);
        end
        $display("test_random done");
    endtask

    task automatic test_reset_mid();
        step(0, 1, 0, '0);
        step(0, 1, 0, '0);
        #2 reset = 1'b1;
        #1;
        total++;
        if (instr_read_out !== 1'b0 || instr_address_out !== RESET_PC || valid_out !== 1'b0 || count_out !== '0)
            $display("FAIL mid_reset got=%b/%h/%b/%0d exp=0/%h/0/0", instr_read_out, instr_address_out, valid_out, count_out, RESET_PC);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1, 1, 0, '0);
        step(1, 1, 0, '0);
        total++;
        if (valid_out !== 1'b1 || pc_out !== RESET_PC)
            $display("FAIL mid_restart got=%b/%h exp=1/%h", valid_out, pc_out, RESET_PC);
        else passed++;
        $display("test_reset_mid done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_slow_mem();
        test_redirect_pending();
        test_redirect_same();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
